// File: rtl/data_mem_responder.sv
// Load/store responder: captures one request, waits WAIT_STATES cycles, then
// commits the write or returns the extended load data with a one-cycle ready pulse.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAST_CNT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, both_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    size_e       size_q;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Request fields as seen by the response logic: live inputs while IDLE
    // (only needed when WAIT_STATES is 0), captured copies otherwise.
    logic             cur_wr, cur_both, cur_uns, cur_err;
    logic [31:0]      cur_addr, cur_wdata;
    size_e            cur_size;
    logic [IDX_W-1:0] word_idx;
    logic             capture, resp_entry, wr_commit;
    logic [3:0]       lane_be;
    logic [31:0]      lane_data;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input size_e       sz,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_wr    = op_wr_q;
        cur_both  = both_q;
        cur_uns   = uns_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_size  = size_q;
        if (state_q == IDLE) begin
            cur_wr    = wr_en;
            cur_both  = rd_en && wr_en;
            cur_uns   = unsigned_ld;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_size  = size_e'(size);
        end
    end

    always_comb begin
        cur_err = cur_both
               || (cur_size == SZ_ILL)
               || ((cur_size == SZ_HALF) && cur_addr[0])
               || ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00))
               || ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
        word_idx = cur_addr[IDX_W+1:2];
    end

    always_comb begin
        lane_be   = 4'b1111;
        lane_data = cur_wdata;
        case (cur_size)
            SZ_BYTE: begin
                lane_be   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        resp_entry = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        resp_entry = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d    = RESP;
                    resp_entry = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == RESP);
        rdata_d = rdata_q;
        err_d   = err_q;
        if (resp_entry) begin
            err_d = cur_err;
            if (cur_err || cur_wr) begin
                rdata_d = 32'h0;
            end else begin
                rdata_d = extend_load(mem[word_idx], cur_addr[1:0], cur_size, cur_uns);
            end
        end
    end

    // Gating with rst keeps a zero-wait write from landing while reset is held.
    assign wr_commit = rst && resp_entry && cur_wr && !cur_err;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            both_q  <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= SZ_BYTE;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            if (capture) begin
                op_wr_q <= wr_en;
                both_q  <= rd_en && wr_en;
                uns_q   <= unsigned_ld;
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= size_e'(size);
            end
        end
    end

    // NOTE: storage has no reset so it maps onto plain RAM; contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_commit && lane_be[i]) begin
                mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule
